// File: rtl/tcdm_apb_responder_if.sv
// Bundles the TCDM responder handshake and the APB master bus of the bridge.
// The slave modport is the bridge's view; master is the view of whatever drives it.
interface tcdm_apb_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    tcdm_req_i;
    logic [ADDR_WIDTH-1:0]   tcdm_add_i;
    logic                    tcdm_wen_i;
    logic [DATA_WIDTH-1:0]   tcdm_wdata_i;
    logic [DATA_WIDTH/8-1:0] tcdm_be_i;
    logic                    tcdm_gnt_o;
    logic                    tcdm_r_valid_o;
    logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o;
    logic                    tcdm_r_opc_o;

    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic                    pwrite_o;
    logic                    psel_o;
    logic                    penable_o;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    modport slave (
        input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        output tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_rdata_o, tcdm_r_opc_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport master (
        output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        input  tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_rdata_o, tcdm_r_opc_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/tcdm_apb_responder.sv
// TCDM-slave to APB-master bridge: one granted TCDM request becomes one APB
// transfer (or an immediate error response), answered with a single r_valid pulse.
module tcdm_apb_responder #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A10_0000,
    parameter logic [ADDR_WIDTH-1:0] WIN_SIZE       = 32'h0010_0000,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input logic                 clk_i,
    input logic                 rst_i,
    tcdm_apb_responder_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    // One extra bit so a window ending exactly at the top of the address space decodes correctly.
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};
    localparam logic [DATA_WIDTH/8-1:0] BE_FULL = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0]   r_rdata_q, r_rdata_d;
    logic                    r_opc_q, r_opc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    gnt;
    logic [ADDR_WIDTH:0]     addr_ext;
    logic                    err_dec;
    logic                    err_strb;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    timeout;

    assign gnt      = bus.tcdm_req_i && (state_q == IDLE) && !rst_i;
    assign addr_ext = {1'b0, bus.tcdm_add_i};
    assign err_dec  = !((addr_ext >= WIN_LO) && (addr_ext < WIN_HI));
    assign err_strb = !bus.tcdm_wen_i && (bus.tcdm_be_i != BE_FULL);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch behind.
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        r_valid_d = 1'b0;
        r_rdata_d = r_rdata_q;
        r_opc_d   = r_opc_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (gnt) begin
                    paddr_d  = bus.tcdm_add_i;
                    pwdata_d = bus.tcdm_wdata_i;
                    pwrite_d = !bus.tcdm_wen_i;
                    if (err_dec || err_strb) begin
                        state_d   = RESP;
                        r_valid_d = 1'b1;
                        r_rdata_d = '0;
                        r_opc_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready is checked first so it wins over a simultaneous timeout.
                if (bus.pready_i) begin
                    state_d   = RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    r_valid_d = 1'b1;
                    r_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    r_opc_d   = bus.pslverr_i;
                    cnt_d     = '0;
                end else if (timeout) begin
                    state_d   = RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    r_valid_d = 1'b1;
                    r_rdata_d = '0;
                    r_opc_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            r_valid_q <= r_valid_d;
            r_rdata_q <= r_rdata_d;
            r_opc_q   <= r_opc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.tcdm_gnt_o     = gnt;
    assign bus.tcdm_r_valid_o = r_valid_q;
    assign bus.tcdm_r_rdata_o = r_rdata_q;
    assign bus.tcdm_r_opc_o   = r_opc_q;
    assign bus.paddr_o        = paddr_q;
    assign bus.pwdata_o       = pwdata_q;
    assign bus.pwrite_o       = pwrite_q;
    assign bus.psel_o         = psel_q;
    assign bus.penable_o      = penable_q;

endmodule

// File: tb/tb_tcdm_apb_responder.sv
// Directed bench for tcdm_apb_responder: zero-wait and wait-state transfers,
// decode/strobe errors, timeout, slave error, back-to-back and mid-transfer reset.
module tb_tcdm_apb_responder;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    tcdm_apb_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

    tcdm_apb_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BASE_ADDR      (32'h1A10_0000),
        .WIN_SIZE       (32'h0010_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic req(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] b);
        bif.tcdm_req_i   = r;
        bif.tcdm_add_i   = a;
        bif.tcdm_wen_i   = w;
        bif.tcdm_wdata_i = d;
        bif.tcdm_be_i    = b;
    endtask

    task automatic apb(input logic rdy, input logic [31:0] rd, input logic err);
        bif.pready_i  = rdy;
        bif.prdata_i  = rd;
        bif.pslverr_i = err;
    endtask

    // Advance to the next falling edge, where inputs are driven and outputs sampled.
    task automatic nstep();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req(1'b1, 32'h1A10_0000, 1'b1, 32'h0, 4'h0);
        apb(1'b0, 32'h0, 1'b0);
        repeat (2) nstep();
        // reset state: outputs low even with a request pending
        check("rst_gnt",    bif.tcdm_gnt_o,     32'd0);
        check("rst_rvalid", bif.tcdm_r_valid_o, 32'd0);
        check("rst_psel",   bif.psel_o,         32'd0);
        check("rst_pen",    bif.penable_o,      32'd0);
        check("rst_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("rst_paddr",  bif.paddr_o,        32'd0);
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        rst_i = 1'b0;

        // read, zero-wait
        nstep();
        req(1'b1, 32'h1A10_0004, 1'b1, 32'h0, 4'h0);
        apb(1'b1, 32'hCAFE_F00D, 1'b0);
        #1;
        check("rd_t0_gnt",  bif.tcdm_gnt_o, 32'd1);
        check("rd_t0_psel", bif.psel_o,     32'd0);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        #1;
        check("rd_t1_gnt",    bif.tcdm_gnt_o, 32'd0);
        check("rd_t1_psel",   bif.psel_o,     32'd1);
        check("rd_t1_pen",    bif.penable_o,  32'd0);
        check("rd_t1_paddr",  bif.paddr_o,    32'h1A10_0004);
        check("rd_t1_pwrite", bif.pwrite_o,   32'd0);
        nstep();
        check("rd_t2_psel",   bif.psel_o,         32'd1);
        check("rd_t2_pen",    bif.penable_o,      32'd1);
        check("rd_t2_rvalid", bif.tcdm_r_valid_o, 32'd0);
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("rd_t3_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("rd_t3_rdata",  bif.tcdm_r_rdata_o, 32'hCAFE_F00D);
        check("rd_t3_opc",    bif.tcdm_r_opc_o,   32'd0);
        check("rd_t3_psel",   bif.psel_o,         32'd0);
        check("rd_t3_pen",    bif.penable_o,      32'd0);
        nstep();
        check("rd_t4_rvalid", bif.tcdm_r_valid_o, 32'd0);
        check("rd_t4_hold",   bif.tcdm_r_rdata_o, 32'hCAFE_F00D);

        // decode error: outside window
        req(1'b1, 32'h1C00_0000, 1'b1, 32'h0, 4'hF);
        #1;
        check("dec_gnt", bif.tcdm_gnt_o, 32'd1);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("dec_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("dec_opc",    bif.tcdm_r_opc_o,   32'd1);
        check("dec_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("dec_psel",   bif.psel_o,         32'd0);
        nstep();
        check("dec_rvalid_end", bif.tcdm_r_valid_o, 32'd0);
        check("dec_psel_end",   bif.psel_o,         32'd0);

        // decode boundaries: last byte of window hits, first byte after misses
        req(1'b1, 32'h1A1F_FFFC, 1'b1, 32'h0, 4'hF);
        apb(1'b1, 32'h0000_00AA, 1'b0);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("top_psel", bif.psel_o, 32'd1);
        nstep();
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("top_rdata", bif.tcdm_r_rdata_o, 32'h0000_00AA);
        check("top_opc",   bif.tcdm_r_opc_o,   32'd0);
        nstep();
        req(1'b1, 32'h1A20_0000, 1'b1, 32'h0, 4'hF);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("past_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("past_opc",    bif.tcdm_r_opc_o,   32'd1);
        check("past_psel",   bif.psel_o,         32'd0);
        nstep();

        // write, 3 wait states
        req(1'b1, 32'h1A10_0010, 1'b0, 32'h1234_5678, 4'hF);
        apb(1'b0, 32'hFFFF_FFFF, 1'b0);
        #1;
        check("wr_gnt", bif.tcdm_gnt_o, 32'd1);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("wr_setup_psel", bif.psel_o,   32'd1);
        check("wr_setup_pen",  bif.penable_o, 32'd0);
        check("wr_pwrite",     bif.pwrite_o, 32'd1);
        check("wr_pwdata_s",   bif.pwdata_o, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            nstep();
            check("wr_wait_pen",    bif.penable_o,      32'd1);
            check("wr_wait_pwdata", bif.pwdata_o,       32'h1234_5678);
            check("wr_wait_rvalid", bif.tcdm_r_valid_o, 32'd0);
        end
        nstep();
        apb(1'b1, 32'hFFFF_FFFF, 1'b0);
        check("wr_acc4_pen",  bif.penable_o, 32'd1);
        check("wr_acc4_addr", bif.paddr_o,   32'h1A10_0010);
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("wr_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("wr_opc",    bif.tcdm_r_opc_o,   32'd0);
        check("wr_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("wr_psel",   bif.psel_o,         32'd0);
        nstep();

        // strobe error on write
        req(1'b1, 32'h1A10_0000, 1'b0, 32'hAAAA_5555, 4'b0011);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("strb_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("strb_opc",    bif.tcdm_r_opc_o,   32'd1);
        check("strb_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("strb_psel",   bif.psel_o,         32'd0);
        nstep();

        // timeout: exactly 4 ACCESS cycles
        req(1'b1, 32'h1A10_0020, 1'b1, 32'h0, 4'h0);
        apb(1'b0, 32'h5555_5555, 1'b0);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("to_setup", bif.psel_o, 32'd1);
        for (int i = 0; i < 4; i++) begin
            nstep();
            check("to_acc_pen",    bif.penable_o,      32'd1);
            check("to_acc_rvalid", bif.tcdm_r_valid_o, 32'd0);
        end
        nstep();
        check("to_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("to_opc",    bif.tcdm_r_opc_o,   32'd1);
        check("to_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("to_psel",   bif.psel_o,         32'd0);
        check("to_pen",    bif.penable_o,      32'd0);
        apb(1'b1, 32'hDEAD_BEEF, 1'b0);
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("to_late_rvalid", bif.tcdm_r_valid_o, 32'd0);
        check("to_late_rdata",  bif.tcdm_r_rdata_o, 32'd0);
        check("to_late_psel",   bif.psel_o,         32'd0);

        // pslverr on read
        req(1'b1, 32'h1A10_0030, 1'b1, 32'h0, 4'h0);
        apb(1'b1, 32'h0BAD_0BAD, 1'b1);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        nstep();
        check("slverr_pen", bif.penable_o, 32'd1);
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("slverr_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("slverr_opc",    bif.tcdm_r_opc_o,   32'd1);
        check("slverr_rdata",  bif.tcdm_r_rdata_o, 32'h0BAD_0BAD);
        nstep();

        // back-to-back reads with req held high
        req(1'b1, 32'h1A10_0040, 1'b1, 32'h0, 4'h0);
        apb(1'b1, 32'h1111_1111, 1'b0);
        #1;
        check("b2b_gnt1", bif.tcdm_gnt_o, 32'd1);
        nstep();
        check("b2b_s1_gnt",  bif.tcdm_gnt_o, 32'd0);
        check("b2b_s1_psel", bif.psel_o,     32'd1);
        nstep();
        check("b2b_a1_gnt", bif.tcdm_gnt_o, 32'd0);
        nstep();
        apb(1'b1, 32'h2222_2222, 1'b0);
        check("b2b_r1_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("b2b_r1_rdata",  bif.tcdm_r_rdata_o, 32'h1111_1111);
        check("b2b_r1_gnt",    bif.tcdm_gnt_o,     32'd0);
        nstep();
        req(1'b1, 32'h1A10_0044, 1'b1, 32'h0, 4'h0);
        #1;
        check("b2b_gnt2",  bif.tcdm_gnt_o, 32'd1);
        check("b2b_gap",   bif.psel_o,     32'd0);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        check("b2b_s2_paddr", bif.paddr_o, 32'h1A10_0044);
        nstep();
        nstep();
        apb(1'b0, 32'h0, 1'b0);
        check("b2b_r2_rvalid", bif.tcdm_r_valid_o, 32'd1);
        check("b2b_r2_rdata",  bif.tcdm_r_rdata_o, 32'h2222_2222);
        nstep();

        // reset during ACCESS
        req(1'b1, 32'h1A10_0050, 1'b1, 32'h0, 4'h0);
        apb(1'b0, 32'h3333_3333, 1'b0);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        nstep();
        check("mrst_pen_before", bif.penable_o, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check("mrst_psel",   bif.psel_o,         32'd0);
        check("mrst_pen",    bif.penable_o,      32'd0);
        check("mrst_rvalid", bif.tcdm_r_valid_o, 32'd0);
        nstep();
        rst_i = 1'b0;
        apb(1'b1, 32'h9999_9999, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nstep();
            check("mrst_no_rvalid", bif.tcdm_r_valid_o, 32'd0);
            check("mrst_no_psel",   bif.psel_o,         32'd0);
        end
        req(1'b1, 32'h1A10_0060, 1'b1, 32'h0, 4'h0);
        apb(1'b1, 32'h0000_0077, 1'b0);
        #1;
        check("mrst_regnt", bif.tcdm_gnt_o, 32'd1);
        nstep();
        req(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        nstep();
        nstep();
        check("mrst_rvalid2", bif.tcdm_r_valid_o, 32'd1);
        check("mrst_rdata2",  bif.tcdm_r_rdata_o, 32'h0000_0077);
        check("mrst_opc2",    bif.tcdm_r_opc_o,   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcdm_apb_responder.md
Name: tcdm_apb_responder

Overview:
- TCDM-slave-to-APB-master bridge. It is the responder end of the XBAR_TCDM_BUS req/gnt/r_valid protocol that the fabric-controller core issues on its data port.
- It sits on an L2-side crossbar slave port and converts each granted TCDM transaction into exactly one APB transfer to a peripheral window.
- It returns data, or an error opcode, to the initiator, and supports address decoding, strobe checking and a per-transfer timeout.

Parameters:
- ADDR_WIDTH, 32, width of TCDM address and APB paddr.
- DATA_WIDTH, 32, data width. Fixed at 32; byte-enable width is DATA_WIDTH/8.
- BASE_ADDR, 32'h1A10_0000, first address of the decoded window.
- WIN_SIZE, 32'h0010_0000, window size in bytes. Hit when BASE_ADDR <= add < BASE_ADDR+WIN_SIZE.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without pready. 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tcdm_req_i  in  1  request valid.
- tcdm_add_i  in  ADDR_WIDTH  byte address.
- tcdm_wen_i  in  1  1=read, 0=write.
- tcdm_wdata_i  in  32  write data.
- tcdm_be_i  in  4  byte enables.
- tcdm_gnt_o  out  1  grant, combinational.
- tcdm_r_valid_o  out  1  response valid, one-cycle pulse.
- tcdm_r_rdata_o  out  32  read data.
- tcdm_r_opc_o  out  1  response error flag.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  32  APB write data.
- pwrite_o  out  1  APB direction.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- prdata_i  in  32  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset asserted mid-transfer aborts immediately and produces no response; the initiator must re-issue.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Grant: tcdm_gnt_o = tcdm_req_i && state==IDLE. At most one outstanding transaction. gnt is 0 in SETUP/ACCESS/RESP.
- On grant:
  - latch add, wdata, ~wen into paddr/pwdata/pwrite registers.
  - Compute err_dec = address outside the window.
  - Compute err_strb = write && be != 4'b1111.
  - If err_dec or err_strb: go to RESP with opc=1, rdata=0, and no APB activity.
  - Otherwise go to SETUP. Reads ignore be; the full word is read.
- SETUP: psel=1, penable=0, one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwdata/pwrite are held stable throughout SETUP and ACCESS.
  - pready=1: capture prdata (reads; 0 for writes) and pslverr into opc, then go to RESP. psel/penable drop to 0 in the next cycle.
  - pready=0: increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to RESP with opc=1, rdata=0. psel/penable are deasserted; a late pready is ignored.
  - pready and timeout in the same cycle: pready wins.
- RESP: r_valid=1 for exactly one cycle with registered rdata/opc, then IDLE. The counter clears on leaving ACCESS.
  - r_rdata/r_opc hold their values after RESP until the next response.
  - r_valid is also issued for writes.
- Latency:
  - Success with zero-wait APB: gnt at T0, SETUP T1, ACCESS T2, r_valid T3.
  - Decode/strobe error: r_valid at T1.
  - Back-to-back requests: the next gnt is no earlier than the cycle after r_valid.
- Request dropped with no grant: no effect. Inputs are sampled only in the grant cycle.
- Window arithmetic: compare in ADDR_WIDTH+1 bits so that BASE_ADDR+WIN_SIZE wrapping at 2^32 decodes correctly.

Test Plan:
- Read, zero-wait: req, add=0x1A10_0004, wen=1; APB returns prdata=0xCAFE_F00D, pready=1 on the first ACCESS cycle -> gnt at T0, psel T1-T2, penable T2, r_valid T3 with rdata=0xCAFE_F00D, opc=0.
- Write, 3 wait states: add=0x1A10_0010, wdata=0x1234_5678, be=4'hF; pready on the 4th ACCESS cycle -> pwrite=1, pwdata stable throughout, r_valid one cycle after pready, opc=0.
- Errors without APB access:
  - add=0x1C00_0000 -> r_valid at T1, opc=1, rdata=0, psel never asserted.
  - Write with be=4'b0011 -> same response.
- Timeout and pslverr, with TIMEOUT_CYCLES=4:
  - pready held 0 -> exactly 4 ACCESS cycles, then r_valid, opc=1, rdata=0; a pready pulse afterwards is ignored.
  - Separate run: pready=1 with pslverr=1 -> opc=1.
- Back-to-back: req held high for two reads -> second gnt exactly one cycle after the first r_valid; no overlapping psel; each response's rdata matches its APB transfer.
- Reset mid-ACCESS: assert rst_i while penable=1 -> psel/penable/r_valid go to 0 asynchronously, no r_valid after release, next req granted normally.
